// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the default processor count, bus and address widths, the address
// type used on every address port, and the state encodings of the read and
// write channel FSMs.
package mem_arbiter_pkg;

   localparam int PROC_COUNT = 4;
   localparam int BUS_WIDTH  = 32;
   localparam int ADDR_W     = 16;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rd_state_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_HOLD = 1'b1
   } wr_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker used once per arbiter channel.
// Ports:
//   req_i    - per-processor request vector
//   ptr_i    - index where the search starts (highest priority this cycle)
//   gnt_o    - one-hot grant for the winner (all zero when no request)
//   any_o    - at least one request present
//   winner_o - index of the winning processor
// The pointer register itself lives in the parent so each channel can decide
// when a grant actually takes effect.
module rr_arbiter #(
   parameter  int NPROC = 4,
   localparam int PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1
) (
   input  logic [NPROC-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NPROC-1:0] gnt_o,
   output logic             any_o,
   output logic [PTR_W-1:0] winner_o
);

   // Walk from ptr_i upwards, wrapping modulo NPROC; the first requester met wins.
   // The sum is one bit wider so the wrap works for non-power-of-two counts.
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      gnt_o    = '0;
      any_o    = 1'b0;
      winner_o = '0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < NPROC; i++) begin
         sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NPROC)) begin
            sum = sum - (PTR_W+1)'(NPROC);
         end
         idx = sum[PTR_W-1:0];
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            gnt_o[idx] = 1'b1;
            winner_o   = idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter sitting between the processor pool and the dual-port
// data memory. Read and write channels each have their own round-robin
// pointer and FSM and run completely independently.
// Ports:
//   i_clk, i_rstn       - clock, asynchronous active-low reset
//   i_req_rd, i_req_wr  - per-processor level requests, held until granted
//   i_addr, i_data      - per-processor address (shared rd/wr) and write data
//   i_wr_size           - per-processor write size, forwarded untouched
//   o_grant_rd/_wr      - one-hot single-cycle grant pulses
//   o_valid, o_rd_data  - one-hot read-valid pulse and broadcast read data
//   o_mem_rd_*          - memory read port (strobe, address, returned data)
//   o_mem_wr_*          - memory write port (strobe, address, data, size)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NPROC  = PROC_COUNT,
   parameter int BUS_W  = BUS_WIDTH,
   parameter int RD_LAT = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic [NPROC-1:0]            i_req_rd,
   input  logic [NPROC-1:0]            i_req_wr,
   input  addr_t [NPROC-1:0]           i_addr,
   input  logic [NPROC-1:0][BUS_W-1:0] i_data,
   input  logic [NPROC-1:0][2:0]       i_wr_size,
   output logic [NPROC-1:0]            o_grant_rd,
   output logic [NPROC-1:0]            o_grant_wr,
   output logic [NPROC-1:0]            o_valid,
   output logic [BUS_W-1:0]            o_rd_data,
   output logic                        o_mem_rd_en,
   output addr_t                       o_mem_rd_addr,
   input  logic [BUS_W-1:0]            i_mem_rd_data,
   output logic                        o_mem_wr_en,
   output addr_t                       o_mem_wr_addr,
   output logic [BUS_W-1:0]            o_mem_wr_data,
   output logic [2:0]                  o_mem_wr_size
);

   localparam int PTR_W = (NPROC > 1) ? $clog2(NPROC) : 1;
   localparam int CNT_W = $clog2(RD_LAT + 1);

   rd_state_e        rdState_q;
   wr_state_e        wrState_q;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] rdCnt_q;
   logic [NPROC-1:0] rdOwner_q;

   logic [NPROC-1:0] rdGnt, wrGnt;
   logic             rdAny, wrAny;
   logic [PTR_W-1:0] rdWinner, wrWinner;

   rr_arbiter #(.NPROC(NPROC)) u_rd_rr (
      .req_i    (i_req_rd),
      .ptr_i    (rdPtr_q),
      .gnt_o    (rdGnt),
      .any_o    (rdAny),
      .winner_o (rdWinner)
   );

   rr_arbiter #(.NPROC(NPROC)) u_wr_rr (
      .req_i    (i_req_wr),
      .ptr_i    (wrPtr_q),
      .gnt_o    (wrGnt),
      .any_o    (wrAny),
      .winner_o (wrWinner)
   );

   // A pointer only moves when its channel actually issues a grant, i.e. the
   // FSM is idle and someone is requesting; it then points just past the winner.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      if (rdState_q == R_IDLE && rdAny) begin
         rdPtr_d = (rdWinner == PTR_W'(NPROC-1)) ? '0 : rdWinner + 1'b1;
      end
      if (wrState_q == W_IDLE && wrAny) begin
         wrPtr_d = (wrWinner == PTR_W'(NPROC-1)) ? '0 : wrWinner + 1'b1;
      end
   end

   // Read channel: grant and strobe the memory, wait out the memory latency,
   // then present the captured data with a valid pulse to the owning proc.
   // The counter is loaded with RD_LAT and runs down to zero, so the capture
   // happens in the cycle the memory drives data, RD_LAT cycles after the strobe.
   // A reset in the middle simply discards the outstanding read.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rdState_q     <= R_IDLE;
         rdPtr_q       <= '0;
         rdCnt_q       <= '0;
         rdOwner_q     <= '0;
         o_grant_rd    <= '0;
         o_valid       <= '0;
         o_rd_data     <= '0;
         o_mem_rd_en   <= 1'b0;
         o_mem_rd_addr <= '0;
      end else begin
         rdPtr_q     <= rdPtr_d;
         o_grant_rd  <= '0;
         o_valid     <= '0;
         o_mem_rd_en <= 1'b0;
         case (rdState_q)
            R_IDLE: begin
               if (rdAny) begin
                  o_grant_rd    <= rdGnt;
                  o_mem_rd_en   <= 1'b1;
                  o_mem_rd_addr <= i_addr[rdWinner];
                  rdOwner_q     <= rdGnt;
                  rdCnt_q       <= CNT_W'(RD_LAT);
                  rdState_q     <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (rdCnt_q == '0) begin
                  o_valid   <= rdOwner_q;
                  o_rd_data <= i_mem_rd_data;
                  rdState_q <= R_RESP;
               end else begin
                  rdCnt_q <= rdCnt_q - 1'b1;
               end
            end
            R_RESP: begin
               rdState_q <= R_IDLE;
            end
            default: begin
               rdState_q <= R_IDLE;
            end
         endcase
      end
   end

   // Write channel: grant and write in one shot, then spend one bubble cycle
   // so the granted proc has time to drop its level request before the next
   // arbitration round looks at it.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wrState_q     <= W_IDLE;
         wrPtr_q       <= '0;
         o_grant_wr    <= '0;
         o_mem_wr_en   <= 1'b0;
         o_mem_wr_addr <= '0;
         o_mem_wr_data <= '0;
         o_mem_wr_size <= '0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         o_grant_wr  <= '0;
         o_mem_wr_en <= 1'b0;
         case (wrState_q)
            W_IDLE: begin
               if (wrAny) begin
                  o_grant_wr    <= wrGnt;
                  o_mem_wr_en   <= 1'b1;
                  o_mem_wr_addr <= i_addr[wrWinner];
                  o_mem_wr_data <= i_data[wrWinner];
                  o_mem_wr_size <= i_wr_size[wrWinner];
                  wrState_q     <= W_HOLD;
               end
            end
            W_HOLD: begin
               wrState_q <= W_IDLE;
            end
            default: begin
               wrState_q <= W_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus pushes expected grants and
// read responses into queues; a monitor pops and compares them whenever the
// DUT presents a grant, memory strobe or valid pulse.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NP  = PROC_COUNT;
   localparam int BW  = BUS_WIDTH;
   localparam int RDL = 1;

   logic                     i_clk;
   logic                     i_rstn;
   logic [NP-1:0]            i_req_rd;
   logic [NP-1:0]            i_req_wr;
   addr_t [NP-1:0]           i_addr;
   logic [NP-1:0][BW-1:0]    i_data;
   logic [NP-1:0][2:0]       i_wr_size;
   logic [NP-1:0]            o_grant_rd;
   logic [NP-1:0]            o_grant_wr;
   logic [NP-1:0]            o_valid;
   logic [BW-1:0]            o_rd_data;
   logic                     o_mem_rd_en;
   addr_t                    o_mem_rd_addr;
   logic [BW-1:0]            i_mem_rd_data;
   logic                     o_mem_wr_en;
   addr_t                    o_mem_wr_addr;
   logic [BW-1:0]            o_mem_wr_data;
   logic [2:0]               o_mem_wr_size;

   typedef struct {
      int            cyc;
      logic [NP-1:0] gnt;
      addr_t         addr;
      logic [BW-1:0] data;
      logic [2:0]    size;
   } exp_t;

   exp_t rdGntQ[$];
   exp_t rdValQ[$];
   exp_t wrGntQ[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mem_arbiter #(.NPROC(NP), .BUS_W(BW), .RD_LAT(RDL)) dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_req_rd      (i_req_rd),
      .i_req_wr      (i_req_wr),
      .i_addr        (i_addr),
      .i_data        (i_data),
      .i_wr_size     (i_wr_size),
      .o_grant_rd    (o_grant_rd),
      .o_grant_wr    (o_grant_wr),
      .o_valid       (o_valid),
      .o_rd_data     (o_rd_data),
      .o_mem_rd_en   (o_mem_rd_en),
      .o_mem_rd_addr (o_mem_rd_addr),
      .i_mem_rd_data (i_mem_rd_data),
      .o_mem_wr_en   (o_mem_wr_en),
      .o_mem_wr_addr (o_mem_wr_addr),
      .o_mem_wr_data (o_mem_wr_data),
      .o_mem_wr_size (o_mem_wr_size)
   );

   // Free-running clock and a cycle counter that advances on every rising edge.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Read-only memory contents, with the one hand-picked word for 0x40.
   function automatic logic [BW-1:0] romData(addr_t a);
      if (a == 16'h0040) return 32'h0000_DEAD;
      return {16'hC0DE, a};
   endfunction

   // Memory model: data appears RDL cycles after the strobe; a junk word
   // is driven otherwise so an early or late capture shows up.
   logic [BW-1:0] memPipe [RDL];
   always @(posedge i_clk) begin
      memPipe[0] <= o_mem_rd_en ? romData(o_mem_rd_addr) : 32'hBAD0_BAD0;
      for (int i = 1; i < RDL; i++) memPipe[i] <= memPipe[i-1];
   end
   assign i_mem_rd_data = memPipe[RDL-1];

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every DUT-side event against the head of its queue.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rstn) begin
         if (o_grant_rd != '0 || o_mem_rd_en) begin
            if (rdGntQ.size() == 0) begin
               checkOutput("rd_grant_unexpected", 64'({o_mem_rd_en, o_grant_rd}), 64'(0));
            end else begin
               e = rdGntQ.pop_front();
               checkOutput("rd_grant_cycle", 64'(cyc), 64'(e.cyc));
               checkOutput("rd_grant", 64'(o_grant_rd), 64'(e.gnt));
               checkOutput("mem_rd_en", 64'(o_mem_rd_en), 64'(1));
               checkOutput("mem_rd_addr", 64'(o_mem_rd_addr), 64'(e.addr));
            end
         end
         if (o_valid != '0) begin
            if (rdValQ.size() == 0) begin
               checkOutput("rd_valid_unexpected", 64'(o_valid), 64'(0));
            end else begin
               e = rdValQ.pop_front();
               checkOutput("rd_valid_cycle", 64'(cyc), 64'(e.cyc));
               checkOutput("rd_valid", 64'(o_valid), 64'(e.gnt));
               checkOutput("rd_data", 64'(o_rd_data), 64'(e.data));
            end
         end
         if (o_grant_wr != '0 || o_mem_wr_en) begin
            if (wrGntQ.size() == 0) begin
               checkOutput("wr_grant_unexpected", 64'({o_mem_wr_en, o_grant_wr}), 64'(0));
            end else begin
               e = wrGntQ.pop_front();
               checkOutput("wr_grant_cycle", 64'(cyc), 64'(e.cyc));
               checkOutput("wr_grant", 64'(o_grant_wr), 64'(e.gnt));
               checkOutput("mem_wr_en", 64'(o_mem_wr_en), 64'(1));
               checkOutput("mem_wr_addr", 64'(o_mem_wr_addr), 64'(e.addr));
               checkOutput("mem_wr_data", 64'(o_mem_wr_data), 64'(e.data));
               checkOutput("mem_wr_size", 64'(o_mem_wr_size), 64'(e.size));
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkZero(string tag);
      checkOutput({tag, "_grants"}, 64'({o_grant_rd, o_grant_wr, o_valid}), 64'(0));
      checkOutput({tag, "_rd_data"}, 64'(o_rd_data), 64'(0));
      checkOutput({tag, "_mem_rd"}, 64'({o_mem_rd_en, o_mem_rd_addr}), 64'(0));
      checkOutput({tag, "_mem_wr"}, 64'({o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_wr_size}), 64'(0));
   endtask

   task automatic pushExp(inout exp_t q[$], input int c, input int p, input addr_t a,
                          input logic [BW-1:0] d, input logic [2:0] s);
      exp_t e;
      e.cyc  = c;
      e.gnt  = NP'(1) << p;
      e.addr = a;
      e.data = d;
      e.size = s;
      q.push_back(e);
   endtask

   // Single read from an idle channel; the proc drops its request once granted.
   task automatic issueRead(int p, addr_t a, bit expectValid);
      i_addr[p]   = a;
      i_req_rd[p] = 1'b1;
      pushExp(rdGntQ, cyc + 1, p, a, '0, '0);
      if (expectValid) pushExp(rdValQ, cyc + 2 + RDL, p, a, romData(a), '0);
      tick();
      i_req_rd[p] = 1'b0;
   endtask

   task automatic issueWrite(int p, addr_t a, logic [BW-1:0] d, logic [2:0] s);
      i_addr[p]    = a;
      i_data[p]    = d;
      i_wr_size[p] = s;
      i_req_wr[p]  = 1'b1;
      pushExp(wrGntQ, cyc + 1, p, a, d, s);
      tick();
      i_req_wr[p] = 1'b0;
   endtask

   // Wait (bounded) until every expected event has been seen.
   task automatic waitDrain();
      int left;
      for (int i = 0; i < 200; i++) begin
         if (rdGntQ.size() + rdValQ.size() + wrGntQ.size() == 0) break;
         tick();
      end
      left = rdGntQ.size() + rdValQ.size() + wrGntQ.size();
      if (left != 0) begin
         checkOutput("drain_timeout", 64'(left), 64'(0));
         rdGntQ.delete();
         rdValQ.delete();
         wrGntQ.delete();
      end
      repeat (2) tick();
   endtask

   task automatic applyStimulus();
      // Reset with random inputs, then release with everything idle.
      i_rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_req_rd  = NP'($urandom);
         i_req_wr  = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            i_addr[p]    = addr_t'($urandom);
            i_data[p]    = BW'($urandom);
            i_wr_size[p] = 3'($urandom);
         end
         tick();
         checkZero("in_reset");
      end
      i_req_rd  = '0;
      i_req_wr  = '0;
      i_addr    = '0;
      i_data    = '0;
      i_wr_size = '0;
      tick();
      i_rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkZero("idle");
      end

      // Single read, proc2 at 0x40.
      $display("[TB] single read proc2");
      issueRead(2, 16'h0040, 1'b1);
      waitDrain();

      // All four readers held from reset: rotation 0,1,2,3,0, RDL+3 apart.
      $display("[TB] four continuous readers");
      i_rstn = 1'b0;
      tick();
      checkZero("rerst");
      for (int p = 0; p < NP; p++) i_addr[p] = addr_t'(16'h0010 + p);
      i_req_rd = '1;
      i_rstn   = 1'b1;
      for (int j = 0; j < 5; j++) begin
         pushExp(rdGntQ, cyc + 1 + j*(RDL+3), j % NP, addr_t'(16'h0010 + j % NP), '0, '0);
         pushExp(rdValQ, cyc + 2 + RDL + j*(RDL+3), j % NP, addr_t'(16'h0010 + j % NP),
                 romData(addr_t'(16'h0010 + j % NP)), '0);
      end
      repeat (1 + 4*(RDL+3)) tick();
      i_req_rd = '0;
      waitDrain();

      // Move write pointer to 2, then proc1 and proc3 together: 3 first, 1 two cycles later.
      $display("[TB] write round robin");
      issueWrite(1, 16'h0020, 32'h0000_0101, 3'd2);
      waitDrain();
      i_addr[1] = 16'h0021; i_data[1] = 32'h0000_0011; i_wr_size[1] = 3'd1;
      i_addr[3] = 16'h0023; i_data[3] = 32'h0000_0033; i_wr_size[3] = 3'd5;
      i_req_wr[1] = 1'b1;
      i_req_wr[3] = 1'b1;
      pushExp(wrGntQ, cyc + 1, 3, 16'h0023, 32'h0000_0033, 3'd5);
      pushExp(wrGntQ, cyc + 3, 1, 16'h0021, 32'h0000_0011, 3'd1);
      tick();
      i_req_wr[3] = 1'b0;
      repeat (2) tick();
      i_req_wr[1] = 1'b0;
      waitDrain();

      // Proc0 reads and writes 0x8 in the same cycle.
      $display("[TB] simultaneous read and write");
      i_addr[0] = 16'h0008; i_data[0] = 32'hA5A5_5A5A; i_wr_size[0] = 3'd3;
      i_req_rd[0] = 1'b1;
      i_req_wr[0] = 1'b1;
      pushExp(rdGntQ, cyc + 1, 0, 16'h0008, '0, '0);
      pushExp(rdValQ, cyc + 2 + RDL, 0, 16'h0008, romData(16'h0008), '0);
      pushExp(wrGntQ, cyc + 1, 0, 16'h0008, 32'hA5A5_5A5A, 3'd3);
      tick();
      i_req_rd[0] = 1'b0;
      i_req_wr[0] = 1'b0;
      waitDrain();

      // Reset while the read waits on memory: that read never completes.
      $display("[TB] reset during read wait");
      issueRead(1, 16'h0030, 1'b0);
      tick();
      i_rstn = 1'b0;
      tick();
      checkZero("midrst");
      tick();
      checkZero("midrst");
      i_rstn = 1'b1;
      repeat (6) tick();
      issueRead(3, 16'h0050, 1'b1);
      waitDrain();
   endtask

   initial begin
      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

endmodule
